// File: rtl/spm_dma.sv
// spm_dma: block-copy initiator on the MEM-side scratchpad port; MEM stage grants access via spm_gnt.
// Optional fill mode (constant pattern writes) is compiled in when SPM_DMA_FILL_EN is defined.
module spm_dma #(
  parameter int ADDR_W = 12,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset_,
  input  logic              cfg_start,
  input  logic [ADDR_W-1:0] cfg_src,
  input  logic [ADDR_W-1:0] cfg_dst,
  input  logic [ADDR_W:0]   cfg_len,
`ifdef SPM_DMA_FILL_EN
  input  logic              cfg_fill,
  input  logic [DATA_W-1:0] cfg_pattern,
`endif
  output logic              busy,
  output logic              done,
  input  logic              spm_gnt,
  output logic [ADDR_W-1:0] spm_addr,
  output logic              spm_as_,
  output logic              spm_rw,
  output logic [DATA_W-1:0] spm_wr_data,
  input  logic [DATA_W-1:0] spm_rd_data
);

  typedef enum logic [2:0] {S_IDLE, S_RD, S_LAT, S_WR, S_DONE} state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   sp_q, sp_d;
  logic [ADDR_W-1:0]   dp_q, dp_d;
  logic [ADDR_W:0]     cnt_q, cnt_d;
  logic [DATA_W-1:0]   hold_q, hold_d;
  logic                fill_q, fill_d;
  logic                start_fill;
  logic [DATA_W-1:0]   start_hold;

`ifdef SPM_DMA_FILL_EN
  assign start_fill = cfg_fill;
  assign start_hold = cfg_pattern;
`else
  assign start_fill = 1'b0;
  assign start_hold = '0;
`endif

  always_ff @(posedge clk or negedge reset_) begin
    if (!reset_) begin
      state_q <= S_IDLE;
      sp_q    <= '0;
      dp_q    <= '0;
      cnt_q   <= '0;
      hold_q  <= '0;
      fill_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sp_q    <= sp_d;
      dp_q    <= dp_d;
      cnt_q   <= cnt_d;
      hold_q  <= hold_d;
      fill_q  <= fill_d;
    end
  end

  // Strobes are decoded from state and grant so the port is released the same cycle grant drops.
  always_comb begin
    state_d     = state_q;
    sp_d        = sp_q;
    dp_d        = dp_q;
    cnt_d       = cnt_q;
    hold_d      = hold_q;
    fill_d      = fill_q;
    busy        = 1'b0;
    done        = 1'b0;
    spm_as_     = 1'b1;
    spm_rw      = 1'b1;
    spm_addr    = '0;
    spm_wr_data = '0;
    case (state_q)
      S_IDLE: begin
        if (cfg_start) begin
          sp_d   = cfg_src;
          dp_d   = cfg_dst;
          cnt_d  = cfg_len;
          fill_d = start_fill;
          if (start_fill) hold_d = start_hold;
          if (cfg_len == '0)   state_d = S_DONE;
          else if (start_fill) state_d = S_WR;
          else                 state_d = S_RD;
        end
      end
      S_RD: begin
        busy = 1'b1;
        if (spm_gnt) begin
          spm_as_  = 1'b0;
          spm_addr = sp_q;
          state_d  = S_LAT;
        end
      end
      S_LAT: begin
        busy    = 1'b1;
        hold_d  = spm_rd_data;
        state_d = S_WR;
      end
      S_WR: begin
        busy = 1'b1;
        if (spm_gnt) begin
          spm_as_     = 1'b0;
          spm_rw      = 1'b0;
          spm_addr    = dp_q;
          spm_wr_data = hold_q;
          sp_d        = sp_q + ADDR_W'(1);
          dp_d        = dp_q + ADDR_W'(1);
          cnt_d       = cnt_q - (ADDR_W+1)'(1);
          if (cnt_q == (ADDR_W+1)'(1)) state_d = S_DONE;
          else if (fill_q)             state_d = S_WR;
          else                         state_d = S_RD;
        end
      end
      S_DONE: begin
        done    = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_spm_dma.sv
// tb_spm_dma: directed bench for spm_dma with a behavioural scratchpad model.
// Fill-mode step is included when SPM_DMA_FILL_EN is defined.
module tb_spm_dma;

  logic        clk = 1'b0;
  logic        reset_ = 1'b0;
  logic        cfg_start = 1'b0;
  logic [11:0] cfg_src = '0;
  logic [11:0] cfg_dst = '0;
  logic [12:0] cfg_len = '0;
  logic        cfg_fill = 1'b0;
  logic [31:0] cfg_pattern = '0;
  logic        busy, done;
  logic        spm_gnt = 1'b1;
  logic [11:0] spm_addr;
  logic        spm_as_, spm_rw;
  logic [31:0] spm_wr_data;
  logic [31:0] spm_rd_data = '0;

  int total = 0;
  int bad = 0;

  spm_dma #(.ADDR_W(12), .DATA_W(32)) dut (
    .clk(clk), .reset_(reset_), .cfg_start(cfg_start),
    .cfg_src(cfg_src), .cfg_dst(cfg_dst), .cfg_len(cfg_len),
`ifdef SPM_DMA_FILL_EN
    .cfg_fill(cfg_fill), .cfg_pattern(cfg_pattern),
`endif
    .busy(busy), .done(done), .spm_gnt(spm_gnt), .spm_addr(spm_addr),
    .spm_as_(spm_as_), .spm_rw(spm_rw), .spm_wr_data(spm_wr_data),
    .spm_rd_data(spm_rd_data)
  );

  always #5 clk = ~clk;

  // Scratchpad model with a bench-side preload port; read data appears one cycle after the strobe.
  logic [31:0] mem [0:4095];
  logic        pre_we = 1'b0;
  logic [11:0] pre_addr = '0;
  logic [31:0] pre_data = '0;
  logic [11:0] rd_log [$];
  int          wr_cnt = 0;
  int          strobe_cnt = 0;
  int          viol = 0;

  always @(posedge clk) begin
    if (pre_we) mem[pre_addr] <= pre_data;
    if (!spm_as_ && spm_gnt) begin
      if (spm_rw) begin
        spm_rd_data <= mem[spm_addr];
        rd_log.push_back(spm_addr);
      end else begin
        mem[spm_addr] <= spm_wr_data;
        wr_cnt <= wr_cnt + 1;
      end
    end
  end

  always @(negedge clk) begin
    if (!spm_as_) strobe_cnt <= strobe_cnt + 1;
    if (!spm_as_ && !spm_gnt) viol <= viol + 1;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic preload(input logic [11:0] a, input logic [31:0] d);
    pre_we = 1'b1; pre_addr = a; pre_data = d;
    tick();
    pre_we = 1'b0;
  endtask

  task automatic start(input logic [11:0] src, input logic [11:0] dst, input logic [12:0] len);
    cfg_src = src; cfg_dst = dst; cfg_len = len; cfg_start = 1'b1;
    tick();
    cfg_start = 1'b0;
  endtask

  task automatic wait_done(input int maxc, input bit stall, output int cyc);
    cyc = 1;
    while (done !== 1'b1 && cyc < maxc) begin
      if (stall) spm_gnt = ~spm_gnt;
      tick();
      cyc++;
    end
    spm_gnt = 1'b1;
    chk("done_reached", done, 1'b1);
  endtask

  int cyc;
  int wr0;
  int st0;
  int rb;

  initial begin
    #3;
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_as", spm_as_, 1'b1);
    chk("rst_rw", spm_rw, 1'b1);
    chk("rst_addr", spm_addr, 12'h000);
    chk("rst_wdata", spm_wr_data, 32'h0);
    #10 reset_ = 1'b1;
    tick();

    for (int i = 0; i < 4; i++) preload(12'h010 + 12'(i), 32'hA0A0_0000 + i);
    preload(12'hFFE, 32'hC0C0_0000);
    preload(12'hFFF, 32'hC0C0_0001);
    preload(12'h000, 32'hC0C0_0002);
    preload(12'h300, 32'h5555_5555);

    // Plain copy with continuous grant.
    wr0 = wr_cnt;
    rb = rd_log.size();
    start(12'h010, 12'h100, 13'd4);
    chk("copy_busy", busy, 1'b1);
    wait_done(40, 1'b0, cyc);
    chk("copy_cycles", cyc, 13);
    chk("copy_busy_at_done", busy, 1'b0);
    tick();
    chk("copy_done_pulse", done, 1'b0);
    for (int i = 0; i < 4; i++) chk("copy_data", mem[12'h100 + 12'(i)], 32'hA0A0_0000 + i);
    chk("copy_writes", wr_cnt - wr0, 4);
    chk("copy_reads", rd_log.size() - rb, 4);

    // Same copy with grant alternating every cycle.
    start(12'h010, 12'h140, 13'd4);
    wait_done(80, 1'b1, cyc);
    chk("stall_later", cyc > 13, 1'b1);
    tick();
    for (int i = 0; i < 4; i++) chk("stall_data", mem[12'h140 + 12'(i)], 32'hA0A0_0000 + i);

    // Source wrap, plus a start pulse while busy that must be ignored.
    wr0 = wr_cnt;
    rb = rd_log.size();
    start(12'hFFE, 12'h020, 13'd3);
    cfg_src = 12'h010; cfg_dst = 12'h300; cfg_len = 13'd1; cfg_start = 1'b1;
    tick();
    cfg_start = 1'b0;
    wait_done(40, 1'b0, cyc);
    tick();
    chk("wrap_rd0", rd_log[rb], 12'hFFE);
    chk("wrap_rd1", rd_log[rb+1], 12'hFFF);
    chk("wrap_rd2", rd_log[rb+2], 12'h000);
    for (int i = 0; i < 3; i++) chk("wrap_data", mem[12'h020 + 12'(i)], 32'hC0C0_0000 + i);
    chk("ignore_start_mem", mem[12'h300], 32'h5555_5555);
    chk("wrap_writes", wr_cnt - wr0, 3);
    tick();
    chk("ignore_start_idle", busy, 1'b0);

    // Zero length: no access, done on the next cycle.
    st0 = strobe_cnt;
    start(12'h010, 12'h200, 13'd0);
    chk("zero_done", done, 1'b1);
    chk("zero_busy", busy, 1'b0);
    tick();
    chk("zero_done_off", done, 1'b0);
    chk("zero_busy2", busy, 1'b0);
    chk("zero_no_strobe", strobe_cnt - st0, 0);

    // Asynchronous reset during the second write of an 8-word copy.
    wr0 = wr_cnt;
    start(12'h010, 12'h180, 13'd8);
    for (int i = 0; i < 5; i++) tick();
    chk("mid_wr_strobe", spm_as_, 1'b0);
    chk("mid_wr_rw", spm_rw, 1'b0);
    chk("mid_wr_addr", spm_addr, 12'h181);
    reset_ = 1'b0;
    #1;
    chk("arst_as", spm_as_, 1'b1);
    chk("arst_busy", busy, 1'b0);
    chk("arst_addr", spm_addr, 12'h000);
    #2 reset_ = 1'b1;
    tick();
    chk("arst_writes", wr_cnt - wr0, 1);
    chk("arst_w0", mem[12'h180], 32'hA0A0_0000);
    start(12'h012, 12'h1C0, 13'd1);
    wait_done(20, 1'b0, cyc);
    chk("post_rst_cycles", cyc, 4);
    tick();
    chk("post_rst_data", mem[12'h1C0], 32'hA0A0_0002);

`ifdef SPM_DMA_FILL_EN
    wr0 = wr_cnt;
    cfg_fill = 1'b1;
    cfg_pattern = 32'hDEAD_BEEF;
    start(12'h000, 12'h200, 13'd5);
    cfg_fill = 1'b0;
    wait_done(20, 1'b0, cyc);
    chk("fill_cycles", cyc, 6);
    tick();
    chk("fill_writes", wr_cnt - wr0, 5);
    for (int i = 0; i < 5; i++) chk("fill_data", mem[12'h200 + 12'(i)], 32'hDEAD_BEEF);
`endif

    chk("as_without_gnt", viol, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not reach the end");
    $fatal(1, "timeout");
  end

endmodule
